// File: rtl/unit_pkg.sv
// rtl/unit_pkg.sv - shared constants, state encoding and type-profile helpers for unit slots
// Purpose : default parameters shared with the enemy-side block, FSM state
//           encoding, and the per-type health/power profile functions.
// Ports   : none (package).
// Config  : UNIT_REGEN_EN (used by unit_slot) enables per-tick health regen.
package unit_pkg;

    localparam int UNIT_POS_W          = 9;
    localparam int UNIT_HP_W           = 8;
    localparam int UNIT_DMG_W          = 8;
    localparam int UNIT_TYPE_W         = 2;
    localparam int UNIT_RESPAWN_CYCLES = 10;
    localparam int UNIT_ATK_PERIOD     = 4;

    localparam logic [1:0] ST_IDLE_ENC     = 2'd0;
    localparam logic [1:0] ST_SPAWN_ENC    = 2'd1;
    localparam logic [1:0] ST_ALIVE_ENC    = 2'd2;
    localparam logic [1:0] ST_COOLDOWN_ENC = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE     = ST_IDLE_ENC,
        ST_SPAWN    = ST_SPAWN_ENC,
        ST_ALIVE    = ST_ALIVE_ENC,
        ST_COOLDOWN = ST_COOLDOWN_ENC
    } unit_state_e;

    // Health profile: all-ones of hp_w bits, halved per type step above 1.
    function automatic logic [31:0] type_hp(input logic [31:0] t, input int hp_w);
        logic [31:0] ones;
        ones = (hp_w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << hp_w) - 32'd1);
        return (t == 32'd0) ? 32'd0 : (ones >> (t - 32'd1));
    endfunction

    // Power profile: highest type lands on the MSB of the damage word.
    function automatic logic [31:0] type_pow(input logic [31:0] t, input int dmg_w,
                                             input int type_w);
        int num_types;
        num_types = (1 << type_w) - 1;
        return (t == 32'd0) ? 32'd0 : (32'd1 << (dmg_w - 1 - num_types + int'(t)));
    endfunction

endpackage

// File: rtl/unit_cooldown_timer.sv
// rtl/unit_cooldown_timer.sv - loadable down-counter with done flag for the respawn cooldown
// Purpose : load_i arms the counter with CYCLES-1; en_i counts it down to 0;
//           done_o is high while the count is 0.
// Ports   : clk, reset (async, active-high), load_i, en_i, done_o.
module unit_cooldown_timer #(
    parameter int CYCLES = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic load_i,
    input  logic en_i,
    output logic done_o
);

    localparam int CNT_W = (CYCLES > 1) ? $clog2(CYCLES + 1) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = CNT_W'(CYCLES - 1);
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign done_o = (cnt_q == '0);

endmodule

// File: rtl/unit_slot.sv
// rtl/unit_slot.sv - one purchasable lane-battle unit: spawn, advance, attack, die, cool down
// Purpose : IDLE -> SPAWN -> ALIVE -> COOLDOWN -> IDLE lifecycle of one unit.
// Ports   : clk, reset (async, active-high); move_tick, damage_tick, damage_in,
//           purchase, type_sel, enemy_front in; position, damage_out, unit_type,
//           ready, died out (all registered or decoded from state).
// Config  : UNIT_REGEN_EN - when defined, each move_tick without a damage_tick
//           heals 1, saturating at the type's spawn health.
module unit_slot
    import unit_pkg::*;
#(
    parameter int POS_W          = UNIT_POS_W,
    parameter int HP_W           = UNIT_HP_W,
    parameter int DMG_W          = UNIT_DMG_W,
    parameter int TYPE_W         = UNIT_TYPE_W,
    parameter int RESPAWN_CYCLES = UNIT_RESPAWN_CYCLES,
    parameter int ATK_PERIOD     = UNIT_ATK_PERIOD
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              move_tick,
    input  logic              damage_tick,
    input  logic [DMG_W-1:0]  damage_in,
    input  logic              purchase,
    input  logic [TYPE_W-1:0] type_sel,
    input  logic [POS_W-1:0]  enemy_front,
    output logic [POS_W-1:0]  position,
    output logic [DMG_W-1:0]  damage_out,
    output logic [TYPE_W-1:0] unit_type,
    output logic              ready,
    output logic              died
);

    localparam int ATK_W = (ATK_PERIOD > 1) ? $clog2(ATK_PERIOD) : 1;

    unit_state_e       state_q;
    logic [TYPE_W-1:0] sel_type_q, unit_type_q;
    logic [HP_W-1:0]   health_q, health_d, hp_load;
    logic [DMG_W-1:0]  power_q, pow_load, damage_out_q;
    logic [POS_W-1:0]  position_q;
    logic [ATK_W-1:0]  atk_q;
    logic              died_q;
    logic              kill, advance, cd_done;

    assign hp_load  = HP_W'(type_hp(32'(sel_type_q), HP_W));
    assign pow_load = DMG_W'(type_pow(32'(sel_type_q), DMG_W, TYPE_W));

    // Equality kills; compare at a common width so either operand may be wider.
    assign kill    = damage_tick && (32'(health_q) <= 32'(damage_in));
    assign advance = (enemy_front < position_q) && (position_q != '0);

    // Surviving damage is strictly below health, so the narrowed subtract cannot wrap.
    always_comb begin
        health_d = health_q;
        if (damage_tick) begin
            health_d = health_q - HP_W'(damage_in);
        end
`ifdef UNIT_REGEN_EN
        else if (move_tick &&
                 (health_q < HP_W'(type_hp(32'(unit_type_q), HP_W)))) begin
            health_d = health_q + 1'b1;
        end
`endif
    end

    unit_cooldown_timer #(
        .CYCLES (RESPAWN_CYCLES)
    ) u_cooldown (
        .clk    (clk),
        .reset  (reset),
        .load_i ((state_q == ST_ALIVE) && kill),
        .en_i   (state_q == ST_COOLDOWN),
        .done_o (cd_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            sel_type_q   <= '0;
            unit_type_q  <= '0;
            health_q     <= '0;
            power_q      <= '0;
            position_q   <= '1;
            damage_out_q <= '0;
            atk_q        <= '0;
            died_q       <= 1'b0;
        end else begin
            died_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (purchase && (type_sel != '0)) begin
                        sel_type_q <= type_sel;
                        state_q    <= ST_SPAWN;
                    end
                end
                ST_SPAWN: begin
                    unit_type_q  <= sel_type_q;
                    health_q     <= hp_load;
                    power_q      <= pow_load;
                    position_q   <= '1;
                    atk_q        <= '0;
                    damage_out_q <= '0;
                    state_q      <= ST_ALIVE;
                end
                ST_ALIVE: begin
                    if (kill) begin
                        // Death wins over any movement or attack this cycle.
                        state_q      <= ST_COOLDOWN;
                        unit_type_q  <= '0;
                        damage_out_q <= '0;
                        position_q   <= '1;
                        health_q     <= '0;
                        died_q       <= 1'b1;
                    end else begin
                        health_q <= health_d;
                        if (move_tick) begin
                            if (advance) begin
                                position_q   <= position_q - 1'b1;
                                damage_out_q <= '0;
                                atk_q        <= '0;
                            end else begin
                                damage_out_q <= (atk_q == '0) ? power_q : '0;
                                atk_q        <= (atk_q == ATK_W'(ATK_PERIOD - 1)) ?
                                                '0 : atk_q + 1'b1;
                            end
                        end
                    end
                end
                ST_COOLDOWN: begin
                    if (cd_done) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign position   = position_q;
    assign damage_out = damage_out_q;
    assign unit_type  = unit_type_q;
    assign ready      = (state_q == ST_IDLE);
    assign died       = died_q;

endmodule

// File: tb/tb_unit_slot.sv
// tb/tb_unit_slot.sv - self-checking bench for unit_slot with a behavioural slot model
module tb_unit_slot;

    logic       clk = 1'b0;
    logic       reset;
    logic       move_tick, damage_tick, purchase;
    logic [7:0] damage_in;
    logic [1:0] type_sel;
    logic [8:0] enemy_front;
    logic [8:0] position;
    logic [7:0] damage_out;
    logic [1:0] unit_type;
    logic       ready, died;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model: lifecycle phase as text-like codes, plain integers.
    int m_phase;     // 0 idle, 1 spawning, 2 alive, 3 cooling down
    int m_pending, m_type, m_hp, m_pow, m_pos, m_dmg, m_engaged, m_died;
    int m_edge, m_free_edge;

    unit_slot dut (
        .clk         (clk),
        .reset       (reset),
        .move_tick   (move_tick),
        .damage_tick (damage_tick),
        .damage_in   (damage_in),
        .purchase    (purchase),
        .type_sel    (type_sel),
        .enemy_front (enemy_front),
        .position    (position),
        .damage_out  (damage_out),
        .unit_type   (unit_type),
        .ready       (ready),
        .died        (died)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_pending = 0; m_type = 0; m_hp = 0; m_pow = 0;
        m_pos = 511; m_dmg = 0; m_engaged = 0; m_died = 0; m_free_edge = 0;
    endtask

    task automatic model_step(input bit pu, input int ts, input bit mt, input bit dt,
                              input int din, input int ef);
        m_edge++;
        m_died = 0;
        if (m_phase == 0) begin
            if (pu && ts != 0) begin
                m_pending = ts;
                m_phase   = 1;
            end
        end else if (m_phase == 1) begin
            m_type = m_pending;
            m_hp   = 255 / (1 << (m_pending - 1));
            m_pow  = 1 << (4 + m_pending);
            m_pos  = 511; m_dmg = 0; m_engaged = 0;
            m_phase = 2;
        end else if (m_phase == 2) begin
            if (dt && m_hp <= din) begin
                m_phase = 3; m_type = 0; m_dmg = 0; m_pos = 511; m_hp = 0;
                m_died = 1;
                m_free_edge = m_edge + 10;
            end else begin
                if (dt) m_hp = m_hp - din;
`ifdef UNIT_REGEN_EN
                else if (mt && m_hp < 255 / (1 << (m_type - 1))) m_hp = m_hp + 1;
`endif
                if (mt) begin
                    if (ef < m_pos && m_pos != 0) begin
                        m_pos = m_pos - 1; m_dmg = 0; m_engaged = 0;
                    end else begin
                        // Attack on engaged ticks 1, 1+P, 1+2P ... since last advance.
                        m_dmg = (m_engaged % 4 == 0) ? m_pow : 0;
                        m_engaged++;
                    end
                end
            end
        end else begin
            if (m_edge >= m_free_edge) m_phase = 0;
        end
    endtask

    task automatic compare_all();
        chk("position",   int'(position),   m_pos);
        chk("damage_out", int'(damage_out), m_dmg);
        chk("unit_type",  int'(unit_type),  m_type);
        chk("ready",      int'(ready),      (m_phase == 0) ? 1 : 0);
        chk("died",       int'(died),       m_died);
    endtask

    task automatic step(input bit pu, input int ts, input bit mt, input bit dt,
                        input int din, input int ef);
        purchase    = pu;
        type_sel    = 2'(ts);
        move_tick   = mt;
        damage_tick = dt;
        damage_in   = 8'(din);
        enemy_front = 9'(ef);
        @(posedge clk);
        model_step(pu, ts, mt, dt, din, ef);
        #1;
        compare_all();
    endtask

    task automatic idle_steps(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        reset = 1'b1;
        purchase = 0; type_sel = 0; move_tick = 0; damage_tick = 0;
        damage_in = 0; enemy_front = 0;
        m_edge = 0;
        model_reset();
        #12;
        compare_all();
        chk("reset_position_lit", int'(position), 'h1FF);
        chk("reset_ready_lit", int'(ready), 1);
        reset = 1'b0;

        // type 0 purchase ignored
        step(1, 0, 0, 0, 0, 0);
        chk("type0_ready_lit", int'(ready), 1);
        // purchase type 2: ready drops in SPAWN, type valid one cycle later
        step(1, 2, 0, 0, 0, 0);
        chk("spawn_ready_lit", int'(ready), 0);
        chk("spawn_type_lit", int'(unit_type), 0);
        step(0, 0, 0, 0, 0, 0);
        chk("alive_type_lit", int'(unit_type), 2);
        step(0, 0, 1, 0, 0, 'h100);
        chk("advance_pos_lit", int'(position), 'h1FE);

        // engaged: attack on ticks 1, 5, 9
        for (int k = 1; k <= 9; k++) begin
            step(0, 0, 1, 0, 0, 'h1FE);
            chk("engaged_dmg_lit", int'(damage_out), (k % 4 == 1) ? 'h40 : 0);
        end
        step(0, 0, 0, 0, 0, 'h1FE);
        chk("dmg_hold_lit", int'(damage_out), 'h40);

        // 127 - 0x40 = 0x3F survives; 0x3F then kills by equality
        step(0, 0, 0, 1, 'h40, 0);
        chk("survive_died_lit", int'(died), 0);
        step(0, 0, 0, 1, 'h3F, 0);
        chk("kill_died_lit", int'(died), 1);
        chk("kill_type_lit", int'(unit_type), 0);
        for (int i = 1; i <= 10; i++) begin
            step(i == 3, 1, 0, 0, 0, 0);
            chk("cooldown_ready_lit", int'(ready), (i == 10) ? 1 : 0);
        end
        step(0, 0, 0, 0, 0, 0);
        chk("no_queued_buy_lit", int'(ready), 1);

        // simultaneous damage and move: health 126, position 0x1FE
        step(1, 2, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 1, 'h100);
        chk("both_pos_lit", int'(position), 'h1FE);
        chk("both_died_lit", int'(died), 0);
        step(0, 0, 0, 1, 126, 0);
        chk("both_kill_lit", int'(died), 1);
        idle_steps(10);

        // regen: 127-2=0x7D, three move ticks, then 0x7E damage
        step(1, 2, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 2, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0, 0);
        step(0, 0, 0, 1, 'h7E, 0);
`ifdef UNIT_REGEN_EN
        chk("regen_died_lit", int'(died), 0);
        step(0, 0, 0, 1, 255, 0);
`else
        chk("noregen_died_lit", int'(died), 1);
`endif
        idle_steps(11);

        // asynchronous reset mid-life: no died pulse
        step(1, 3, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0, 0);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        chk("async_reset_type_lit", int'(unit_type), 0);
        #2;
        reset = 1'b0;

        // randomized phase
        for (int i = 0; i < 800; i++) begin
            bit pu, mt, dt;
            int din;
            pu  = ($urandom_range(0, 7) == 0);
            mt  = ($urandom_range(0, 1) == 1);
            dt  = ($urandom_range(0, 3) == 0);
            din = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 255))
                                               : int'($urandom_range(0, 30));
            step(pu, int'($urandom_range(0, 3)), mt, dt, din,
                 int'($urandom_range(470, 511)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
